// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: zero-latency mux, grant locked to one requester until its last beat fires.
// Define RR_BURST_ARBITER_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module rr_burst_arbiter #(
  parameter int PORTS  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PORTS-1:0]         req_valid_i,
  input  logic [PORTS-1:0]         req_last_i,
  input  logic [PORTS*DATA_W-1:0]  req_data_i,
  output logic [PORTS-1:0]         req_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_last_o,
  output logic [$clog2(PORTS)-1:0] out_idx_o,
`ifdef RR_BURST_ARBITER_STALL_CNT_EN
  output logic [31:0]              stall_cnt_o,
`endif
  input  logic                     out_ready_i
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel;
  logic [IDX_W:0]   cand;
  logic             found;
  logic             sel_vld;
  logic             fire;
  logic [DATA_W-1:0] data_arr [PORTS];

  for (genvar g = 0; g < PORTS; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[g*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(PORTS - 1)) ? '0 : x + 1'b1;
  endfunction

  // Rotating priority search starting at ptr; winner defaults to ptr when nobody is valid.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(PORTS)) begin
        cand = cand - (IDX_W+1)'(PORTS);
      end
      if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign sel     = (state_q == LOCKED) ? owner_q : winner;
  assign sel_vld = (state_q == LOCKED) ? req_valid_i[owner_q] : found;
  assign fire    = sel_vld & out_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (sel_vld) begin
      req_ready_o[sel] = out_ready_i;
    end
  end

  assign out_valid_o = sel_vld;
  assign out_idx_o   = sel;
  assign out_last_o  = sel_vld & req_last_i[sel];
  assign out_data_o  = sel_vld ? data_arr[sel] : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          if (fire && req_last_i[winner]) begin
            ptr_d = nxt_idx(winner);
          end else begin
            // A stalled single-beat grant also locks, so a later, higher-priority arrival cannot steal it.
            state_d = LOCKED;
            owner_d = winner;
          end
        end
      end
      LOCKED: begin
        if (fire && req_last_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = nxt_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

`ifdef RR_BURST_ARBITER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid_o && !out_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: round-robin order, burst lock, stall lock, owner gap, reset mid-burst.
module tb_rr_burst_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_last_i;
  logic [127:0] req_data_i;
  logic [3:0]   req_ready_o;
  logic         out_valid_o;
  logic [31:0]  out_data_o;
  logic         out_last_o;
  logic [1:0]   out_idx_o;
  logic         out_ready_i;
`ifdef RR_BURST_ARBITER_STALL_CNT_EN
  logic [31:0]  stall_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [39:0] act;
  logic [39:0] exp_v;
  logic [6:0]  exp_s;

  rr_burst_arbiter #(.PORTS(4), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_idx_o   (out_idx_o),
`ifdef RR_BURST_ARBITER_STALL_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  assign act = {out_valid_o, out_idx_o, req_ready_o, out_last_o, out_data_o};

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy);
    req_valid_i = v;
    req_last_i  = l;
    out_ready_i = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    n_chk++;
    if (act !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", act, 40'd0);
    end
    drive(4'b0100, 4'b0000, 1'b1);
    #1;
    exp_v = {1'b1, 2'd2, 4'b0100, 1'b0, dat(2)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL reset_route: got %h want %h", act, exp_v);
    end
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_round_robin();
    drive(4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      exp_v = {1'b1, 2'(k % 4), 4'(1 << (k % 4)), 1'b1, dat(k % 4)};
      n_chk++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got %h want %h", k, act, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_burst_lock();
    drive(4'b0001, 4'b0001, 1'b1);
    next_cycle();
    for (int b = 0; b < 3; b++) begin
      drive(4'b0111, (b == 2) ? 4'b0010 : 4'b0000, 1'b1);
      @(negedge clk_i);
      exp_v = {1'b1, 2'd1, 4'b0010, (b == 2), dat(1)};
      n_chk++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL burst_beat%0d: got %h want %h", b, act, exp_v);
      end
      next_cycle();
    end
    drive(4'b0101, 4'b0100, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd2, 4'b0100, 1'b1, dat(2)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL burst_next_grant: got %h want %h", act, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_stall_lock();
    drive(4'b1000, 4'b1111, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      exp_v = {1'b1, 2'd3, 4'b0000, 1'b1, dat(3)};
      n_chk++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got %h want %h", c, act, exp_v);
      end
      next_cycle();
    end
    drive(4'b1001, 4'b1111, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd3, 4'b1000, 1'b1, dat(3)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL stall_lock_held: got %h want %h", act, exp_v);
    end
    next_cycle();
    drive(4'b0001, 4'b1111, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd0, 4'b0001, 1'b1, dat(0)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL stall_then_req0: got %h want %h", act, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_alone();
    drive(4'b0001, 4'b0001, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd0, 4'b0001, 1'b1, dat(0)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL alone_wrap: got %h want %h", act, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_owner_gap();
    drive(4'b0101, 4'b0000, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd2, 4'b0100, 1'b0, dat(2)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL gap_first_beat: got %h want %h", act, exp_v);
    end
    next_cycle();
    drive(4'b0001, 4'b0001, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      exp_s = {1'b0, 2'd2, 4'b0000};
      n_chk++;
      if (act[39:33] !== exp_s) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: got %h want %h", c, act[39:33], exp_s);
      end
      next_cycle();
    end
    drive(4'b0101, 4'b0100, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd2, 4'b0100, 1'b1, dat(2)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL gap_resume: got %h want %h", act, exp_v);
    end
    next_cycle();
    drive(4'b0001, 4'b0001, 1'b1);
    @(negedge clk_i);
    exp_v = {1'b1, 2'd0, 4'b0001, 1'b1, dat(0)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL gap_after_release: got %h want %h", act, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    drive(4'b1000, 4'b0000, 1'b1);
    next_cycle();
    drive(4'b1001, 4'b1111, 1'b1);
    #1;
    exp_v = {1'b1, 2'd3, 4'b1000, 1'b1, dat(3)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL rstmid_locked: got %h want %h", act, exp_v);
    end
    rst_i = 1'b1;
    #1;
    exp_v = {1'b1, 2'd0, 4'b0001, 1'b1, dat(0)};
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h want %h", act, exp_v);
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL rstmid_after_release: got %h want %h", act, exp_v);
    end
    next_cycle();
  endtask

`ifdef RR_BURST_ARBITER_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_i = 1'b1;
    drive(4'b0001, 4'b0000, 1'b0);
    next_cycle();
    rst_i = 1'b0;
    n_chk++;
    if (stall_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL stallcnt_reset: got %0d want 0", stall_cnt_o);
    end
    repeat (5) next_cycle();
    n_chk++;
    if (stall_cnt_o !== 32'd5) begin
      n_fail++;
      $display("FAIL stallcnt_five: got %0d want 5", stall_cnt_o);
    end
    drive(4'b0001, 4'b0001, 1'b1);
    next_cycle();
    n_chk++;
    if (stall_cnt_o !== 32'd5) begin
      n_fail++;
      $display("FAIL stallcnt_hold: got %0d want 5", stall_cnt_o);
    end
  endtask
`endif

  initial begin
    req_data_i = {dat(3), dat(2), dat(1), dat(0)};
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_stall_lock();
    test_alone();
    test_owner_gap();
    test_reset_mid_burst();
`ifdef RR_BURST_ARBITER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port req_valid_i, input, PORTS, per-requester valid.
REQ-006 SHALL have port req_last_i, input, PORTS, per-requester last beat of burst.
REQ-007 SHALL have port req_data_i, input, PORTS*DATA_W, per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready_o, output, PORTS, per-requester ready.
REQ-009 SHALL have port out_valid_o, output, 1, downstream valid.
REQ-010 SHALL have port out_data_o, output, DATA_W, downstream payload.
REQ-011 SHALL have port out_last_o, output, 1, downstream last.
REQ-012 SHALL have port out_idx_o, output, $clog2(PORTS), index of the routed requester.
REQ-013 SHALL have port out_ready_i, input, 1, downstream ready.

Function
REQ-014 SHALL implement two states, IDLE and LOCKED, plus a round-robin pointer ptr and an owner register.
REQ-015 In IDLE, winner SHALL be the first index with req_valid_i set, searching ptr, ptr+1, ... modulo PORTS.
REQ-016 In IDLE with any valid, SHALL route the winner combinationally in the same cycle: out_valid_o=1; out_data_o, out_last_o and out_idx_o taken from the winner; req_ready_o[winner]=out_ready_i; all other ready bits 0.
REQ-017 In IDLE with no valid, out_valid_o=0, req_ready_o=0, out_idx_o=ptr, out_last_o=0, out_data_o=0.
REQ-018 IDLE, winner fires (valid&ready) with last=1: SHALL stay IDLE and set ptr<=(winner+1) mod PORTS.
REQ-019 IDLE, winner fires with last=0, or winner valid but out_ready_i=0: SHALL go LOCKED with owner<=winner; ptr unchanged.
REQ-020 In LOCKED, SHALL route only the owner: out_valid_o=req_valid_i[owner]; req_ready_o[owner]=out_ready_i; all other ready bits 0; out_idx_o=owner.
REQ-021 LOCKED, owner fires with last=1: SHALL go IDLE and set ptr<=(owner+1) mod PORTS.
REQ-022 LOCKED, owner drops valid mid-burst: SHALL stay LOCKED with out_valid_o=0; no other requester is granted.
REQ-023 Zero-latency datapath: an accepted beat appears on the output in the same cycle; throughput 1 beat/cycle.
REQ-024 Pointer wrap: owner=PORTS-1 completing SHALL set ptr=0.
REQ-025 A requester asserting valid alone SHALL be granted regardless of ptr.

Reset
REQ-026 While rst_i=1 (asynchronous assert), state=IDLE, ptr=0, owner=0; outputs SHALL then follow REQ-016/REQ-017.
REQ-027 Reset asserted mid-burst SHALL abandon the lock; after release, arbitration restarts from ptr=0.

Configuration
REQ-028 With macro RR_BURST_ARBITER_STALL_CNT_EN defined, SHALL add output port stall_cnt_o (32 bits), counting cycles with out_valid_o=1 and out_ready_i=0; saturating at 0xFFFFFFFF; reset to 0.
REQ-029 Without RR_BURST_ARBITER_STALL_CNT_EN, the stall_cnt_o port and counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-030 All 4 valid, last=1, out_ready_i=1 for 8 cycles after reset -> out_idx_o sequence 0,1,2,3,0,1,2,3.
REQ-031 Req 1 sends a 3-beat burst (last on beat 3) while req 0 and req 2 are valid -> out_idx_o=1 for 3 fires, req_ready_o[0]=req_ready_o[2]=0 throughout, next grant goes to 2.
REQ-032 Req 3 valid alone with out_ready_i=0 for 2 cycles, then req 0 also valid and out_ready_i=1 -> req 3 is granted first (lock held), then req 0.
REQ-033 Owner 2 drops valid for 2 cycles mid-burst while req 0 is valid -> out_valid_o=0, req_ready_o=0 during the gap, burst resumes on 2.
REQ-034 Assert rst_i during a LOCKED burst by req 3 -> state IDLE, ptr=0 immediately; with req 0 and req 3 valid after release, req 0 granted.
REQ-035 With RR_BURST_ARBITER_STALL_CNT_EN, valid held with out_ready_i=0 for 5 cycles -> stall_cnt_o=5.
